mat_byte_loader: RTL and testbench

- Assembles a pair of 2x2 matrices, A then B, from a serial element stream with a valid/ready handshake.
- Presents them as packed row-major words with a valid/ready handshake on the output side.
- Sits in front of the combinational 2x2 matrix multiplier and produces its packed A/B operand format.
- Buffers exactly one operand pair, checks frame boundaries, and supports synchronous abort.

---
 rtl/mat_pkg.sv | 8 +
 rtl/mat_pack_reg.sv | 26 ++
 rtl/mat_byte_loader.sv | 81 ++++++++
 tb/tb_mat_byte_loader.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// mat_pkg: shared constants and loader state encoding for the 2x2 matrix datapath.
package mat_pkg;
  localparam int ELEM_W_DEF = 8;
  localparam int N_ELEM = 4;
  localparam int MAT_W_DEF = N_ELEM * ELEM_W_DEF;
  localparam int FRAME_LEN = 2 * N_ELEM;
  typedef enum logic [1:0] {IDLE, LOAD, PRESENT} state_t;
endpackage

// File: rtl/mat_pack_reg.sv
// mat_pack_reg: A/B operand storage; writes one element at its row-major packed position.
module mat_pack_reg
  import mat_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [2:0]                 idx,
  input  logic [ELEM_W-1:0]          din,
  output logic [N_ELEM*ELEM_W-1:0]   m_a,
  output logic [N_ELEM*ELEM_W-1:0]   m_b
);
  localparam int MAT_W = N_ELEM * ELEM_W;
  logic [2*MAT_W-1:0] data_q, data_d;
  always_comb begin
    data_d = data_q;
    if (we) data_d[2*MAT_W-1-int'(idx)*ELEM_W -: ELEM_W] = din;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) data_q <= '0;
    else data_q <= data_d;
  assign m_a = data_q[2*MAT_W-1 -: MAT_W];
  assign m_b = data_q[MAT_W-1:0];
endmodule

// File: rtl/mat_byte_loader.sv
// mat_byte_loader: assembles an A/B 2x2 operand pair from an 8-element stream and holds it for the consumer.
module mat_byte_loader
  import mat_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [ELEM_W-1:0]         s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [N_ELEM*ELEM_W-1:0]  m_a,
  output logic [N_ELEM*ELEM_W-1:0]  m_b,
  output logic                      frame_err
);
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic s_ready_q, s_ready_d, m_valid_q, m_valid_d, err_q, err_d;
  logic acc, last_idx, we;
  // clear gates acceptance internally so outputs stay purely registered
  assign acc = s_valid && s_ready_q && !clear;
  assign last_idx = idx_q == 3'(FRAME_LEN - 1);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    err_d = 1'b0;
    we = 1'b0;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD:
        if (acc) begin
          if (s_last == last_idx) begin
            we = 1'b1;
            idx_d = idx_q + 3'd1;
            state_d = last_idx ? PRESENT : LOAD;
          end else begin
            idx_d = '0;
            err_d = 1'b1;
          end
        end
      PRESENT: state_d = m_ready ? LOAD : PRESENT;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = LOAD;
      idx_d = '0;
    end
    s_ready_d = state_d == LOAD;
    m_valid_d = state_d == PRESENT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      err_q <= err_d;
    end
  mat_pack_reg #(.ELEM_W(ELEM_W)) u_pack (
    .clk(clk),
    .rst_n(rst_n),
    .we(we),
    .idx(idx_q),
    .din(s_data),
    .m_a(m_a),
    .m_b(m_b)
  );
  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_mat_byte_loader.sv
// tb_mat_byte_loader: directed plus random stimulus against a queue-based frame model.
module tb_mat_byte_loader;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [7:0] s_data = '0;
  logic s_ready, m_valid, frame_err;
  logic [31:0] m_a, m_b;
  int n_chk = 0, n_fail = 0;
  bit idle = 1, pres = 0, e_ready = 0, e_valid = 0, e_err = 0;
  logic [31:0] e_a = '0, e_b = '0;
  byte unsigned q[$];

  mat_byte_loader dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_a(m_a), .m_b(m_b), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("s_ready", 32'(s_ready), 32'(e_ready));
    chk("m_valid", 32'(m_valid), 32'(e_valid));
    chk("frame_err", 32'(frame_err), 32'(e_err));
    if (e_valid || !rst_n) begin
      chk("m_a", m_a, e_a);
      chk("m_b", m_b, e_b);
    end
  endtask

  task automatic model_update();
    e_err = 0;
    if (!rst_n) begin
      idle = 1; pres = 0; q.delete(); e_a = '0; e_b = '0;
    end else if (clear) begin
      idle = 0; pres = 0; q.delete();
    end else if (idle) idle = 0;
    else if (pres) begin
      if (m_ready) pres = 0;
    end else if (s_valid) begin
      q.push_back(s_data);
      if (s_last != (q.size() == 8)) begin
        e_err = 1; q.delete();
      end else if (q.size() == 8) begin
        e_a = {q[0], q[1], q[2], q[3]};
        e_b = {q[4], q[5], q[6], q[7]};
        pres = 1; q.delete();
      end
    end
    e_ready = rst_n && !idle && !pres;
    e_valid = pres;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic mr, input logic clr);
    s_valid = v; s_data = d; s_last = l; m_ready = mr; clear = clr;
    @(posedge clk);
    #1 model_update();
    @(negedge clk);
    check_outs();
  endtask

  task automatic send_frame(input logic [7:0] base, input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 20 && !e_ready; g++) step(0, 8'h00, 0, 1, 0);
      repeat ($urandom_range(0, 2)) step(0, 8'($urandom), 0, 1, 0);
      step(1, base + 8'(i), i == last_at, 1, 0);
    end
  endtask

  initial begin
    @(negedge clk);
    check_outs();
    step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    check_outs();
    step(0, 0, 0, 0, 0);
    chk("ready_after_release", 32'(s_ready), 32'd1);

    send_frame(8'h01, 8, 7);
    chk("basic_valid", 32'(m_valid), 32'd1);
    chk("basic_a", m_a, 32'h01020304);
    chk("basic_b", m_b, 32'h05060708);
    step(0, 0, 0, 1, 0);
    chk("basic_valid_drop", 32'(m_valid), 32'd0);

    send_frame(8'h30, 8, 7);
    repeat (5) step(1, 8'hFF, 0, 0, 0);
    chk("bp_a_hold", m_a, 32'h30313233);
    step(0, 0, 0, 1, 0);
    chk("bp_ready_back", 32'(s_ready), 32'd1);
    send_frame(8'h10, 8, 7);
    chk("bp2_a", m_a, 32'h10111213);
    chk("bp2_b", m_b, 32'h14151617);
    step(0, 0, 0, 1, 0);

    send_frame(8'h50, 3, 2);
    chk("early_err", 32'(frame_err), 32'd1);
    send_frame(8'hA0, 8, 7);
    chk("early_a", m_a, 32'hA0A1A2A3);
    chk("early_b", m_b, 32'hA4A5A6A7);
    step(0, 0, 0, 1, 0);

    send_frame(8'h60, 8, -1);
    chk("miss_err", 32'(frame_err), 32'd1);
    chk("miss_valid", 32'(m_valid), 32'd0);
    send_frame(8'h90, 8, 7);
    chk("miss_next_a", m_a, 32'h90919293);
    step(0, 0, 0, 1, 0);

    send_frame(8'h40, 5, -1);
    rst_n = 1'b0;
    #1 model_update();
    check_outs();
    step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    check_outs();
    send_frame(8'h21, 8, 7);
    chk("rst_a", m_a, 32'h21222324);
    chk("rst_b", m_b, 32'h25262728);

    step(0, 0, 0, 0, 1);
    chk("clr_pres_valid", 32'(m_valid), 32'd0);
    send_frame(8'hC0, 3, -1);
    step(1, 8'hEE, 0, 1, 1);
    chk("clr_no_err", 32'(frame_err), 32'd0);
    send_frame(8'h70, 8, 7);
    chk("clr_a", m_a, 32'h70717273);
    chk("clr_b", m_b, 32'h74757677);

    for (int i = 0; i < 3000; i++) begin
      logic l;
      l = (q.size() == 7) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      step($urandom_range(0, 9) < 7, 8'($urandom), l, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
